// File: rtl/pair_xchg_sched_if.sv
// rtl/pair_xchg_sched_if.sv - request/grant and response bundle between requester fabric and pair_xchg_sched
interface pair_xchg_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CNTW = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [W*NREQ-1:0]    req_a;
  logic [W*NREQ-1:0]    req_b;
  logic [CNTW*NREQ-1:0] req_cnt;
  logic [NREQ-1:0]      grant;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_a;
  logic [W-1:0]         rsp_b;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cnt,
    input  grant, rsp_valid, rsp_id, rsp_a, rsp_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cnt,
    output grant, rsp_valid, rsp_id, rsp_a, rsp_b
  );
endinterface

// File: rtl/pair_xchg_sched.sv
// rtl/pair_xchg_sched.sv - round-robin arbiter/sequencer owning the two-register exchange datapath
// Define PAIR_XCHG_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module pair_xchg_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pair_xchg_sched_if.slave bus,
  output logic             o_busy
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  w_base;
  logic [IDW-1:0]  w_win;
  logic            w_any;
  int              w_idx;
  logic [NREQ-1:0] w_grant;
  logic            w_accept;
  logic            w_rsp_valid_d;
  logic            w_busy_d;

  logic [1:0]      r_op;
  logic [W-1:0]    r_ld_a;
  logic [W-1:0]    r_ld_b;
  logic [CNTW-1:0] r_cnt;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_reg_a;
  logic [W-1:0]    r_reg_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_busy;

`ifdef PAIR_XCHG_SCHED_FIXED_PRIO_EN
  assign w_base = IDW'(NREQ - 1);
`else
  logic [IDW-1:0] r_ptr;
  assign w_base = r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ptr <= IDW'(NREQ - 1);
    else if (w_accept)
      r_ptr <= w_win;
  end
`endif

  // Search starts just above the base so the last winner gets lowest priority.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = (int'(w_base) + i) % NREQ;
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_any;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_EXEC;
      S_EXEC: if (r_op != OP_SWAP || r_cnt <= CNTW'(1)) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant = '0;
    if (w_accept && !i_rst)
      w_grant[w_win] = 1'b1;
    w_rsp_valid_d = (w_next == S_RESP);
    w_busy_d      = (w_next != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op        <= OP_READ;
      r_ld_a      <= '0;
      r_ld_b      <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_reg_a     <= '0;
      r_reg_b     <= W'(1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_valid_d;
      r_busy      <= w_busy_d;
      if (w_rsp_valid_d)
        r_rsp_id <= r_id;
      if (w_accept) begin
        r_op   <= bus.req_op[2*w_win +: 2];
        r_ld_a <= bus.req_a[W*w_win +: W];
        r_ld_b <= bus.req_b[W*w_win +: W];
        r_cnt  <= bus.req_cnt[CNTW*w_win +: CNTW];
        r_id   <= w_win;
      end
      if (r_state == S_EXEC) begin
        case (r_op)
          OP_LOAD: begin
            r_reg_a <= r_ld_a;
            r_reg_b <= r_ld_b;
          end
          OP_CLEAR: begin
            r_reg_a <= '0;
            r_reg_b <= W'(1);
          end
          // A zero count leaves the pair alone, which makes SWAP-0 a READ.
          OP_SWAP: begin
            if (r_cnt != '0) begin
              r_reg_a <= r_reg_b;
              r_reg_b <= r_reg_a;
            end
            r_cnt <= r_cnt - CNTW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.grant     = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_a     = r_reg_a;
  assign bus.rsp_b     = r_reg_b;
  assign o_busy        = r_busy;
endmodule

// File: tb/tb_pair_xchg_sched.sv
// tb/tb_pair_xchg_sched.sv - directed and randomized self-checking bench for pair_xchg_sched
// Honours PAIR_XCHG_SCHED_FIXED_PRIO_EN in its reference model.
module tb_pair_xchg_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CNTW = 4;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  pair_xchg_sched_if #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) bus ();

  pair_xchg_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  logic [1:0]      m_op  [NREQ];
  logic [W-1:0]    m_a   [NREQ];
  logic [W-1:0]    m_b   [NREQ];
  logic [CNTW-1:0] m_cnt [NREQ];
  logic [W-1:0]    m_ra;
  logic [W-1:0]    m_rb;
  int              m_ptr;
  bit              watch_id1 = 1'b0;
  bit              id1_seen  = 1'b0;

  always @(negedge clk)
    if (watch_id1 && bus.rsp_valid === 1'b1 && bus.rsp_id === 2'd1)
      id1_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [CNTW-1:0] cnt);
    m_op[i]  = op;
    m_a[i]   = a;
    m_b[i]   = b;
    m_cnt[i] = cnt;
    bus.req_op[2*i +: 2]       = op;
    bus.req_a[W*i +: W]        = a;
    bus.req_b[W*i +: W]        = b;
    bus.req_cnt[CNTW*i +: CNTW] = cnt;
  endtask

  task automatic model_reset();
    m_ra  = '0;
    m_rb  = 8'h01;
    m_ptr = NREQ - 1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] mask);
    int j;
`ifdef PAIR_XCHG_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++)
      if (mask[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (mask[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic int exec_len(input int w);
    return (m_op[w] == OP_SWAP && m_cnt[w] != 0) ? int'(m_cnt[w]) : 1;
  endfunction

  // An even number of exchanges is a no-op on the pair, an odd number is one exchange.
  task automatic model_apply(input int w);
    logic [W-1:0] t;
    case (m_op[w])
      OP_LOAD:  begin m_ra = m_a[w]; m_rb = m_b[w]; end
      OP_CLEAR: begin m_ra = '0; m_rb = 8'h01; end
      OP_SWAP:  if (m_cnt[w][0]) begin t = m_ra; m_ra = m_rb; m_rb = t; end
      default: ;
    endcase
    m_ptr = w;
  endtask

  task automatic run_txn(input logic [NREQ-1:0] mask, input bit hold, input int wd);
    int w;
    int e;
    int k;
    bit seen;
    w = pick(mask);
    e = exec_len(w);
    bus.req_valid = mask;
    #1;
    check("grant", 32'(bus.grant), 32'(1) << w);
    check("busy_at_grant", 32'(busy), 0);
    model_apply(w);
    tick();
    if (!hold) bus.req_valid[w] = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 40) begin
      if (wd >= 0 && k == 1) bus.req_valid[wd] = 1'b1;
      if (wd >= 0 && k == 2) bus.req_valid[wd] = 1'b0;
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      else begin
        check("grant_while_busy", 32'(bus.grant), 0);
        check("busy_exec", 32'(busy), 1);
        tick();
        k++;
      end
    end
    check("rsp_latency", k, e + 1);
    check("rsp_id", 32'(bus.rsp_id), w);
    check("rsp_a", 32'(bus.rsp_a), 32'(m_ra));
    check("rsp_b", 32'(bus.rsp_b), 32'(m_rb));
    check("busy_resp", 32'(busy), 1);
    tick();
    check("busy_after", 32'(busy), 0);
    check("rsp_valid_after", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    int  cnt_seen;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cnt   = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, OP_READ, 8'h00, 8'h00, 4'd0);
    model_reset();

    // Reset asserted mid-cycle with a request pending.
    #7;
    rst = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_a", 32'(bus.rsp_a), 32'h00);
    check("rst_rsp_b", 32'(bus.rsp_b), 32'h01);
    tick();
    check("rst_grant_held", 32'(bus.grant), 0);
    rst = 1'b0;

    run_txn(4'b0001, 1'b0, -1);
    set_req(2, OP_LOAD, 8'h3C, 8'hA5, 4'd0);
    run_txn(4'b0100, 1'b0, -1);
    set_req(3, OP_SWAP, 8'h00, 8'h00, 4'd3);
    run_txn(4'b1000, 1'b0, -1);
    set_req(0, OP_LOAD, 8'h3C, 8'hA5, 4'd0);
    run_txn(4'b0001, 1'b0, -1);
    set_req(1, OP_SWAP, 8'h00, 8'h00, 4'd4);
    run_txn(4'b0010, 1'b0, -1);
    set_req(3, OP_SWAP, 8'h00, 8'h00, 4'd0);
    run_txn(4'b1000, 1'b0, -1);

    // Full load: every requester holds a READ.
    for (int i = 0; i < NREQ; i++) set_req(i, OP_READ, 8'h00, 8'h00, 4'd0);
    for (int n = 0; n < 5; n++) run_txn(4'b1111, 1'b1, -1);
    bus.req_valid = '0;

    // Reset in EXEC cycle 4 of a SWAP-10.
    set_req(2, OP_SWAP, 8'h00, 8'h00, 4'd10);
    bus.req_valid = 4'b0100;
    #1;
    check("swap10_grant", 32'(bus.grant), 32'(1) << pick(4'b0100));
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("midrst_rsp_a", 32'(bus.rsp_a), 32'h00);
    check("midrst_rsp_b", 32'(bus.rsp_b), 32'h01);
    model_reset();
    tick();
    rst = 1'b0;
    cnt_seen = 0;
    for (int n = 0; n < 14; n++) begin
      if (bus.rsp_valid !== 1'b0) cnt_seen++;
      tick();
    end
    check("midrst_no_rsp", cnt_seen, 0);
    set_req(3, OP_READ, 8'h00, 8'h00, 4'd0);
    set_req(0, OP_READ, 8'h00, 8'h00, 4'd0);
    run_txn(4'b1001, 1'b0, -1);

    // Requester 1 raises and withdraws while the block is busy.
    watch_id1 = 1'b1;
    set_req(2, OP_SWAP, 8'h00, 8'h00, 4'd5);
    run_txn(4'b0100, 1'b0, 1);
    set_req(0, OP_CLEAR, 8'h00, 8'h00, 4'd0);
    run_txn(4'b0001, 1'b0, -1);
    run_txn(4'b1000, 1'b0, -1);
    check("withdrawn_no_rsp", 32'(id1_seen), 0);
    watch_id1 = 1'b0;

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 15)));
      run_txn(4'($urandom_range(1, 15)), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
